decode_pipe: RTL and testbench

Parametrised RV32I decode stage between fetch and execute, built as the successor to the single-format decoder. It decodes all base formats (R/I/S/B/U/J) and reads operands from an integrated register file. Results are held in one output register with valid/ready handshake, load-use stall, flush, and optional writeback bypass. Upstream is the fetch stage; downstream is the ALU/execute stage; the write port is fed by writeback.

---
 rtl/decode_pkg.sv | 32 +++
 rtl/decode_if.sv | 39 +++
 rtl/decode_regfile.sv | 27 ++
 rtl/decode_pipe.sv | 159 +++++++++++++++
 tb/tb_decode_pipe.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared decode types: RV32I opcode constants, ALU source selects and the
// decoded-instruction record held in the decode output register.
package decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {SRC1_RS1 = 3'd0, SRC1_PC = 3'd1, SRC1_ZERO = 3'd2} src1_e;
  typedef enum logic [2:0] {SRC2_RS2 = 3'd0, SRC2_IMM = 3'd1, SRC2_FOUR = 3'd2} src2_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [6:0] alu_op;
    logic       sub_sra;
    src1_e      src1;
    src2_e      src2;
    logic       rd_write;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/decode_if.sv
// Decode stage bus: fetch handshake, hazard/writeback inputs, execute handshake.
interface decode_if #(parameter int XLEN = 32);
  logic            in_valid, in_ready;
  logic [31:0]     instr_in;
  logic [XLEN-1:0] pc_in;
  logic            flush_in;
  logic            ex_load_in;
  logic [4:0]      ex_rd_in;
  logic            wb_write_in;
  logic [4:0]      wb_rd_in;
  logic [XLEN-1:0] wb_value_in;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] pc_out;
  logic [4:0]      rs1_out, rs2_out, rd_out;
  logic [XLEN-1:0] rs1_value_out, rs2_value_out, imm_value_out;
  logic [2:0]      funct3_out;
  logic [6:0]      funct7_out, alu_op_out;
  logic            alu_sub_sra_out;
  logic [2:0]      alu_src1_out, alu_src2_out;
  logic            rd_write_out, illegal_out;

  modport master (
    output in_valid, instr_in, pc_in, flush_in, ex_load_in, ex_rd_in,
           wb_write_in, wb_rd_in, wb_value_in, out_ready,
    input  in_ready, out_valid, pc_out, rs1_out, rs2_out, rd_out,
           rs1_value_out, rs2_value_out, imm_value_out, funct3_out, funct7_out,
           alu_op_out, alu_sub_sra_out, alu_src1_out, alu_src2_out,
           rd_write_out, illegal_out
  );

  modport slave (
    input  in_valid, instr_in, pc_in, flush_in, ex_load_in, ex_rd_in,
           wb_write_in, wb_rd_in, wb_value_in, out_ready,
    output in_ready, out_valid, pc_out, rs1_out, rs2_out, rd_out,
           rs1_value_out, rs2_value_out, imm_value_out, funct3_out, funct7_out,
           alu_op_out, alu_sub_sra_out, alu_src1_out, alu_src2_out,
           rd_write_out, illegal_out
  );
endinterface

// File: rtl/decode_regfile.sv
// NREGS x XLEN register file: two combinational reads, one synchronous write,
// x0 hard-wired to zero. Contents are intentionally not reset.
module decode_regfile #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic            req,
  input  logic            we_i,
  input  logic [4:0]      wa_i,
  input  logic [XLEN-1:0] wd_i,
  input  logic [4:0]      ra1_i,
  input  logic [4:0]      ra2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] mem_q [NREGS];

  always_ff @(posedge req) begin
    if (we_i && (wa_i != 5'd0) && ({1'b0, wa_i} < 6'(NREGS)))
      mem_q[wa_i[AW-1:0]] <= wd_i;
  end

  assign rd1_o = (ra1_i == 5'd0) ? '0 : mem_q[ra1_i[AW-1:0]];
  assign rd2_o = (ra2_i == 5'd0) ? '0 : mem_q[ra2_i[AW-1:0]];
endmodule

// File: rtl/decode_pipe.sv
// RV32I/RV32E decode stage with integrated register file and 1-deep output register.
// DECODE_FWD_EN: bypass writeback data into operands instead of stalling a cycle.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input logic     req,
  input logic     rst_n,
  decode_if.slave bus
);
  logic [31:0]     ins;
  logic [6:0]      opc;
  dec_t            dec_d, dec_q;
  logic [31:0]     imm32;
  logic            use1, use2;
  logic [XLEN-1:0] rf_rd1, rf_rd2, rs1v_d, rs2v_d;
  logic [XLEN-1:0] rs1v_q, rs2v_q, imm_q, pc_q;
  logic            valid_q;
  logic            ld_hit, wb_hit1, wb_hit2, hazard, accept, in_ready;

  assign ins = bus.instr_in;
  assign opc = ins[6:0];

  always_comb begin
    dec_d          = '0;
    imm32          = '0;
    use1           = 1'b0;
    use2           = 1'b0;
    dec_d.rd       = ins[11:7];
    dec_d.funct3   = ins[14:12];
    dec_d.funct7   = ins[31:25];
    dec_d.alu_op   = opc;
    dec_d.src1     = SRC1_RS1;
    dec_d.src2     = SRC2_RS2;
    dec_d.rd_write = 1'b1;
    case (opc)
      OPC_OP: begin
        use1 = 1'b1; use2 = 1'b1;
        dec_d.sub_sra = ins[30];
      end
      OPC_OP_IMM: begin
        use1 = 1'b1; dec_d.src2 = SRC2_IMM;
        imm32 = {{20{ins[31]}}, ins[31:20]};
        dec_d.sub_sra = (ins[14:12] == 3'b101) && ins[30];
      end
      OPC_LOAD: begin
        use1 = 1'b1; dec_d.src2 = SRC2_IMM;
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      OPC_JALR: begin
        use1 = 1'b1; dec_d.src2 = SRC2_FOUR;
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      OPC_STORE: begin
        use1 = 1'b1; use2 = 1'b1; dec_d.src2 = SRC2_IMM; dec_d.rd_write = 1'b0;
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      OPC_BRANCH: begin
        use1 = 1'b1; use2 = 1'b1; dec_d.src2 = SRC2_IMM; dec_d.rd_write = 1'b0;
        imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      OPC_LUI: begin
        dec_d.src1 = SRC1_ZERO; dec_d.src2 = SRC2_IMM;
        imm32 = {ins[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        dec_d.src1 = SRC1_PC; dec_d.src2 = SRC2_IMM;
        imm32 = {ins[31:12], 12'b0};
      end
      OPC_JAL: begin
        dec_d.src1 = SRC1_PC; dec_d.src2 = SRC2_FOUR;
        imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      default: begin
        dec_d.illegal  = 1'b1;
        dec_d.rd_write = 1'b0;
      end
    endcase
    dec_d.rs1 = use1 ? ins[19:15] : 5'd0;
    dec_d.rs2 = use2 ? ins[24:20] : 5'd0;
    // RV32E: any referenced register above x15 makes the instruction illegal
    if (NREGS == 16 && ((use1 && ins[19]) || (use2 && ins[24]) || (dec_d.rd_write && ins[11]))) begin
      dec_d.illegal  = 1'b1;
      dec_d.rd_write = 1'b0;
    end
  end

  decode_regfile #(.NREGS(NREGS), .XLEN(XLEN)) u_rf (
    .req   (req),
    .we_i  (bus.wb_write_in),
    .wa_i  (bus.wb_rd_in),
    .wd_i  (bus.wb_value_in),
    .ra1_i (dec_d.rs1),
    .ra2_i (dec_d.rs2),
    .rd1_o (rf_rd1),
    .rd2_o (rf_rd2)
  );

  assign ld_hit  = bus.ex_load_in && (|bus.ex_rd_in) &&
                   ((use1 && dec_d.rs1 == bus.ex_rd_in) || (use2 && dec_d.rs2 == bus.ex_rd_in));
  assign wb_hit1 = bus.wb_write_in && (|bus.wb_rd_in) && use1 && (dec_d.rs1 == bus.wb_rd_in);
  assign wb_hit2 = bus.wb_write_in && (|bus.wb_rd_in) && use2 && (dec_d.rs2 == bus.wb_rd_in);

`ifdef DECODE_FWD_EN
  assign hazard = bus.in_valid && ld_hit;
  assign rs1v_d = wb_hit1 ? bus.wb_value_in : rf_rd1;
  assign rs2v_d = wb_hit2 ? bus.wb_value_in : rf_rd2;
`else
  // Without the bypass, wait one cycle so the write lands before the read
  assign hazard = bus.in_valid && (ld_hit || wb_hit1 || wb_hit2);
  assign rs1v_d = rf_rd1;
  assign rs2v_d = rf_rd2;
`endif

  assign in_ready = rst_n && (bus.flush_in || ((!valid_q || bus.out_ready) && !hazard));
  assign accept   = bus.in_valid && in_ready && !bus.flush_in;

  always_ff @(posedge req) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      rs1v_q  <= '0;
      rs2v_q  <= '0;
    end else begin
      if (bus.flush_in)      valid_q <= 1'b0;
      else if (accept)       valid_q <= 1'b1;
      else if (bus.out_ready) valid_q <= 1'b0;
      if (accept) begin
        dec_q  <= dec_d;
        pc_q   <= bus.pc_in;
        imm_q  <= XLEN'($signed(imm32));
        rs1v_q <= rs1v_d;
        rs2v_q <= rs2v_d;
      end
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = valid_q;
  assign bus.pc_out          = pc_q;
  assign bus.rs1_out         = dec_q.rs1;
  assign bus.rs2_out         = dec_q.rs2;
  assign bus.rd_out          = dec_q.rd;
  assign bus.rs1_value_out   = rs1v_q;
  assign bus.rs2_value_out   = rs2v_q;
  assign bus.imm_value_out   = imm_q;
  assign bus.funct3_out      = dec_q.funct3;
  assign bus.funct7_out      = dec_q.funct7;
  assign bus.alu_op_out      = dec_q.alu_op;
  assign bus.alu_sub_sra_out = dec_q.sub_sra;
  assign bus.alu_src1_out    = dec_q.src1;
  assign bus.alu_src2_out    = dec_q.src2;
  assign bus.rd_write_out    = dec_q.rd_write;
  assign bus.illegal_out     = dec_q.illegal;
endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: formats, immediates, hazards, backpressure, flush, reset.
module tb_decode_pipe;
  logic req = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  decode_if #(.XLEN(32)) bus ();
  decode_pipe #(.NREGS(32), .XLEN(32)) dut (.req(req), .rst_n(rst_n), .bus(bus));

  always #5 req = ~req;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge req);
    #1;
  endtask

  task automatic offer(input string tag, input logic [31:0] ins, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.instr_in = ins;
    bus.pc_in    = pc;
    #1;
    chk(tag, bus.in_ready, 1);
    step;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid = 0; bus.instr_in = '0; bus.pc_in = '0; bus.flush_in = 0;
    bus.ex_load_in = 0; bus.ex_rd_in = '0; bus.wb_write_in = 0; bus.wb_rd_in = '0;
    bus.wb_value_in = '0; bus.out_ready = 1;

    // reset state
    step; step;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_illegal", bus.illegal_out, 0);
    chk("rst_pc", bus.pc_out, 0);
    rst_n = 1;

    // preload x1 = 0x11, x2 = 0x22 through the writeback port
    bus.wb_write_in = 1; bus.wb_rd_in = 5'd1; bus.wb_value_in = 32'h11; step;
    bus.wb_rd_in = 5'd2; bus.wb_value_in = 32'h22; step;
    bus.wb_write_in = 0;

    offer("rdy_addi", 32'h00500093, 32'h100);   // addi x1,x0,5
    chk("addi_valid", bus.out_valid, 1);
    chk("addi_rd", bus.rd_out, 1);
    chk("addi_imm", bus.imm_value_out, 5);
    chk("addi_src2", bus.alu_src2_out, 1);
    chk("addi_wr", bus.rd_write_out, 1);
    chk("addi_pc", bus.pc_out, 32'h100);
    step;
    chk("drain_valid", bus.out_valid, 0);

    offer("rdy_lui", 32'h123452b7, 32'h104);    // lui x5,0x12345
    chk("lui_imm", bus.imm_value_out, 32'h12345000);
    chk("lui_src1", bus.alu_src1_out, 2);
    chk("lui_rs1", bus.rs1_out, 0);
    chk("lui_rd", bus.rd_out, 5);

    offer("rdy_sw", 32'hFE20AE23, 32'h108);     // sw x2,-4(x1)
    chk("sw_imm", bus.imm_value_out, 32'hFFFFFFFC);
    chk("sw_wr", bus.rd_write_out, 0);
    chk("sw_rs1v", bus.rs1_value_out, 32'h11);
    chk("sw_rs2v", bus.rs2_value_out, 32'h22);

    offer("rdy_beq", 32'hFE208CE3, 32'h10C);    // beq x1,x2,-8
    chk("beq_imm", bus.imm_value_out, 32'hFFFFFFF8);
    chk("beq_wr", bus.rd_write_out, 0);

    offer("rdy_jal", 32'h008000EF, 32'h110);    // jal x1,8
    chk("jal_imm", bus.imm_value_out, 8);
    chk("jal_src1", bus.alu_src1_out, 1);
    chk("jal_src2", bus.alu_src2_out, 2);

    offer("rdy_srai", 32'h4030D093, 32'h114);   // srai x1,x1,3
    chk("srai_sra", bus.alu_sub_sra_out, 1);
    chk("srai_imm", bus.imm_value_out, 32'h403);
    chk("srai_rs2", bus.rs2_out, 0);

    // add x4,x3,x3 offered while writeback writes x3
    bus.wb_write_in = 1; bus.wb_rd_in = 5'd3; bus.wb_value_in = 32'hDEADBEEF;
    bus.in_valid = 1; bus.instr_in = 32'h00318233; bus.pc_in = 32'h118;
    #1;
`ifdef DECODE_FWD_EN
    chk("wb_ready", bus.in_ready, 1);
    step;
    bus.wb_write_in = 0; bus.in_valid = 0;
`else
    chk("wb_stall", bus.in_ready, 0);
    step;
    bus.wb_write_in = 0;
    chk("wb_bubble", bus.out_valid, 0);
    #1;
    chk("wb_ready2", bus.in_ready, 1);
    step;
    bus.in_valid = 0;
`endif
    chk("wb_valid", bus.out_valid, 1);
    chk("wb_rs1v", bus.rs1_value_out, 32'hDEADBEEF);
    chk("wb_rs2v", bus.rs2_value_out, 32'hDEADBEEF);

    // load-use on x2: add x6,x2,x1
    bus.ex_load_in = 1; bus.ex_rd_in = 5'd2;
    bus.in_valid = 1; bus.instr_in = 32'h00110333; bus.pc_in = 32'h11C;
    #1;
    chk("lu_stall", bus.in_ready, 0);
    step;
    chk("lu_bubble", bus.out_valid, 0);
    bus.ex_load_in = 0;
    #1;
    chk("lu_ready", bus.in_ready, 1);
    step;
    bus.in_valid = 0;
    chk("lu_valid", bus.out_valid, 1);
    chk("lu_rd", bus.rd_out, 6);
    chk("lu_rs1v", bus.rs1_value_out, 32'h22);
    chk("lu_rs2v", bus.rs2_value_out, 32'h11);

    // backpressure with a new instruction waiting
    bus.out_ready = 0;
    bus.in_valid = 1; bus.instr_in = 32'h00500093; bus.pc_in = 32'h300;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", bus.in_ready, 0);
      step;
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_rd", bus.rd_out, 6);
      chk("bp_pc", bus.pc_out, 32'h11C);
    end

    // flush drops held and offered instruction
    bus.flush_in = 1;
    #1;
    chk("fl_ready", bus.in_ready, 1);
    step;
    bus.flush_in = 0; bus.in_valid = 0; bus.out_ready = 1;
    chk("fl_valid", bus.out_valid, 0);
    step;
    chk("fl_dropped", bus.out_valid, 0);

    offer("rdy_ill", 32'h0000007F, 32'h140);
    chk("ill_valid", bus.out_valid, 1);
    chk("ill_flag", bus.illegal_out, 1);
    chk("ill_wr", bus.rd_write_out, 0);

    // reset while stalled discards the held instruction
    bus.out_ready = 0;
    rst_n = 0;
    step;
    chk("rst2_valid", bus.out_valid, 0);
    chk("rst2_illegal", bus.illegal_out, 0);
    chk("rst2_pc", bus.pc_out, 0);
    chk("rst2_ready", bus.in_ready, 0);
    rst_n = 1; bus.out_ready = 1;
    step;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
